// File: rtl/sram_1p_front_pkg.sv
// Shared defaults and FSM state type for the single-port SRAM front end.
package sram_1p_front_pkg;

  localparam int unsigned ADDR_W_DEF     = 11;
  localparam int unsigned DATA_W_DEF     = 5;
  localparam int unsigned DEPTH_DEF      = 2048;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sram_1p_front_wbuf.sv
// One-entry posted-write buffer with starvation age and read-forward compare.
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   load, load_addr/data  capture a newly accepted write (wins over drain)
//   drain                 buffered entry is written to the SRAM this cycle
//   rd_addr               address of the read being presented this cycle
//   wb_valid/addr/data    buffered entry
//   starve                entry has waited STARVE_MAX cycles and must drain
//   fwd_hit               rd_addr matches the valid buffered entry
module sram_1p_front_wbuf
  import sram_1p_front_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              starve,
  output logic              fwd_hit
);

  localparam int unsigned AGE_W = (STARVE_MAX == 0) ? 1 : $clog2(STARVE_MAX + 1);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [AGE_W-1:0]  age_q, age_d;

  // Age saturates at the threshold; a load restarts it from zero.
  always_comb begin : wbuf_next
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    age_d   = age_q;
    if (valid_q && !drain && (age_q < AGE_W'(STARVE_MAX))) begin
      age_d = age_q + AGE_W'(1);
    end
    if (drain) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      addr_d  = load_addr;
      data_d  = load_data;
      age_d   = '0;
    end
  end

  always_ff @(posedge clock) begin : wbuf_regs
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      age_q   <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      age_q   <= age_d;
    end
  end

  assign wb_valid = valid_q;
  assign wb_addr  = addr_q;
  assign wb_data  = data_q;
  assign starve   = valid_q && (age_q >= AGE_W'(STARVE_MAX));
  assign fwd_hit  = valid_q && (rd_addr == addr_q);

endmodule

// File: rtl/sram_1p_front.sv
// Front end for a single-port SRAM: sweeps INIT_VAL into every entry after
// reset, then arbitrates one read port and one buffered write port onto the
// SRAM, with read-after-write forwarding from the write buffer.
// Ports:
//   clock, reset                     clock, synchronous active-high reset
//   r_req_valid/ready/addr           read request handshake
//   r_resp_valid/data                read response, one cycle after accept
//   w_req_valid/ready/addr/data      write request handshake
//   init_done                        sweep complete
//   sram_en/wmode/addr/wdata/rdata   SRAM macro port (rdata one cycle late)
// Build option: HOLD_READ_EN makes r_resp_data hold the last response while
// r_resp_valid is low; otherwise it passes sram_rdata through.
module sram_1p_front
  import sram_1p_front_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned INIT_VAL   = 0,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r_req_valid,
  output logic              r_req_ready,
  input  logic [ADDR_W-1:0] r_req_addr,
  output logic              r_resp_valid,
  output logic [DATA_W-1:0] r_resp_data,
  input  logic              w_req_valid,
  output logic              w_req_ready,
  input  logic [ADDR_W-1:0] w_req_addr,
  input  logic [DATA_W-1:0] w_req_data,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic              fwd_q, fwd_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  logic              r_fire, w_fire, wb_drain;
  logic              wb_valid, wb_starve, wb_hit;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] resp_data;

  sram_1p_front_wbuf #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) u_wbuf (
    .clock     (clock),
    .reset     (reset),
    .load      (w_fire),
    .load_addr (w_req_addr),
    .load_data (w_req_data),
    .drain     (wb_drain),
    .rd_addr   (r_req_addr),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .starve    (wb_starve),
    .fwd_hit   (wb_hit)
  );

  // Sweep/run sequencing and SRAM port arbitration; reset silences the port.
  always_comb begin : fsm_next
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_fire      = 1'b0;
    w_fire      = 1'b0;
    wb_drain    = 1'b0;
    r_req_ready = 1'b0;
    w_req_ready = 1'b0;
    init_done   = 1'b0;
    sram_en     = 1'b0;
    sram_wmode  = 1'b0;
    sram_addr   = '0;
    sram_wdata  = '0;
    if (!reset) begin
      unique case (state_q)
        ST_INIT: begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = cnt_q;
          sram_wdata = DATA_W'(INIT_VAL);
          cnt_d      = cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          init_done   = 1'b1;
          // A starved write blocks reads; otherwise reads win the port.
          r_req_ready = !wb_starve;
          r_fire      = r_req_valid && r_req_ready;
          wb_drain    = wb_valid && !r_fire;
          w_req_ready = !wb_valid || wb_drain;
          w_fire      = w_req_valid && w_req_ready;
          if (r_fire) begin
            sram_en   = 1'b1;
            sram_addr = r_req_addr;
          end else if (wb_drain) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = wb_addr;
            sram_wdata = wb_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Forward decision is taken at accept time against the pre-load buffer,
  // so a write accepted alongside the read is never forwarded.
  always_comb begin : resp_next
    resp_valid_d = r_fire;
    fwd_d        = fwd_q;
    fwd_data_d   = fwd_data_q;
    if (r_fire) begin
      fwd_d      = wb_hit;
      fwd_data_d = wb_data;
    end
  end

  always_ff @(posedge clock) begin : main_regs
    if (reset) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      fwd_q        <= 1'b0;
      fwd_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      fwd_q        <= fwd_d;
      fwd_data_q   <= fwd_data_d;
    end
  end

  assign resp_data    = (resp_valid_q && fwd_q) ? fwd_data_q : sram_rdata;
  assign r_resp_valid = resp_valid_q && !reset;

`ifdef HOLD_READ_EN
  logic [DATA_W-1:0] hold_q, hold_d;

  // Remember the last delivered response for the idle cycles that follow.
  always_comb begin : hold_next
    hold_d = hold_q;
    if (resp_valid_q) begin
      hold_d = resp_data;
    end
  end

  always_ff @(posedge clock) begin : hold_regs
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign r_resp_data = reset ? '0 : (resp_valid_q ? resp_data : hold_q);
`else
  assign r_resp_data = reset ? '0 : resp_data;
`endif

endmodule

// File: tb/tb_sram_1p_front.sv
// Scoreboard bench for sram_1p_front: SRAM behavioural model, an
// architectural memory model predicting every read response, and directed
// plus random stimulus.
`timescale 1ns/1ps
module tb_sram_1p_front;

  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 5;
  localparam int unsigned DEPTH = 2048;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          r_req_valid = 1'b0;
  logic          r_req_ready;
  logic [AW-1:0] r_req_addr = '0;
  logic          r_resp_valid;
  logic [DW-1:0] r_resp_data;
  logic          w_req_valid = 1'b0;
  logic          w_req_ready;
  logic [AW-1:0] w_req_addr = '0;
  logic [DW-1:0] w_req_data = '0;
  logic          init_done;
  logic          sram_en;
  logic          sram_wmode;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;

  sram_1p_front dut (
    .clock        (clock),
    .reset        (reset),
    .r_req_valid  (r_req_valid),
    .r_req_ready  (r_req_ready),
    .r_req_addr   (r_req_addr),
    .r_resp_valid (r_resp_valid),
    .r_resp_data  (r_resp_data),
    .w_req_valid  (w_req_valid),
    .w_req_ready  (w_req_ready),
    .w_req_addr   (w_req_addr),
    .w_req_data   (w_req_data),
    .init_done    (init_done),
    .sram_en      (sram_en),
    .sram_wmode   (sram_wmode),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Physical SRAM: garbage while reset is held, so only the sweep can zero it.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= DW'(i * 7 + 3);
    end else if (sram_en) begin
      if (sram_wmode) mem[sram_addr] <= sram_wdata;
      else            sram_rdata     <= mem[sram_addr];
    end
  end

  // Architectural model: reads see all writes accepted in earlier cycles.
  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] ref_mem [DEPTH];

  always @(negedge clock) begin : observer
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    end else begin
      if (r_req_valid && r_req_ready) exp_q.push_back('{data: ref_mem[r_req_addr], cyc: cyc + 1});
      if (w_req_valid && w_req_ready) ref_mem[w_req_addr] = w_req_data;
    end
  end

  always @(negedge clock) begin : monitor
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("resp_missing_at_cycle", exp_q[0].cyc, cyc);
        mon_e = exp_q.pop_front();
      end
      if (r_resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected_queue_size", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_data", int'(r_resp_data), int'(mon_e.data));
          chk("resp_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic samp();
    @(negedge clock);
  endtask

  task automatic idle();
    r_req_valid = 1'b0;
    w_req_valid = 1'b0;
  endtask

  task automatic chk_reset_outs();
    chk("rst_sram_en", int'(sram_en), 0);
    chk("rst_r_req_ready", int'(r_req_ready), 0);
    chk("rst_w_req_ready", int'(w_req_ready), 0);
    chk("rst_r_resp_valid", int'(r_resp_valid), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_r_resp_data", int'(r_resp_data), 0);
  endtask

  task automatic apply_reset(input int n);
    step();
    idle();
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      samp();
      chk_reset_outs();
      step();
    end
    reset = 1'b0;
  endtask

  // Sweep cycle i must write INIT_VAL (0) to address i with handshakes closed.
  task automatic sweep_check(input int n);
    int bad;
    bad = -1;
    for (int i = 0; i < n; i++) begin
      samp();
      if (bad < 0 && !(sram_en && sram_wmode && int'(sram_addr) == i && sram_wdata == DW'(0)
                       && !init_done && !r_req_ready && !w_req_ready)) bad = i;
    end
    chk("sweep_first_bad_index", bad, -1);
  endtask

  initial begin : stim
    apply_reset(3);
    sweep_check(int'(DEPTH));
    samp();
    chk("init_done_cycle_2049", int'(init_done), 1);
    chk("run_r_req_ready", int'(r_req_ready), 1);
    chk("run_idle_sram_en", int'(sram_en), 0);

    // Plain read of address 5.
    step(); r_req_valid = 1'b1; r_req_addr = AW'(5);
    samp();
    chk("rd5_ready", int'(r_req_ready), 1);
    chk("rd5_sram_read", int'(sram_en && !sram_wmode && sram_addr == AW'(5)), 1);
    step(); idle();
    samp();
    chk("rd5_resp_valid", int'(r_resp_valid), 1);
    chk("rd5_resp_data", int'(r_resp_data), 0);

    // Write 7 then read 7 immediately: served from the buffer.
    step(); w_req_valid = 1'b1; w_req_addr = AW'(7); w_req_data = DW'(5'h1A);
    samp();
    chk("fw_w_ready", int'(w_req_ready), 1);
    step(); idle(); r_req_valid = 1'b1; r_req_addr = AW'(7);
    samp();
    chk("fw_sram_is_read", int'(sram_en && !sram_wmode), 1);
    step(); idle();
    samp();
    chk("fw_resp_valid", int'(r_resp_valid), 1);
    chk("fw_resp_data", int'(r_resp_data), 'h1A);
    repeat (3) step();

    // Same-cycle write and read of address 8 returns the old contents.
    step(); r_req_valid = 1'b1; r_req_addr = AW'(8);
    w_req_valid = 1'b1; w_req_addr = AW'(8); w_req_data = DW'(5'h07);
    samp();
    chk("same_w_ready", int'(w_req_ready), 1);
    step(); idle(); r_req_valid = 1'b1; r_req_addr = AW'(8);
    samp();
    chk("same_old_data", int'(r_resp_data), 0);
    step(); idle();
    samp();
    chk("same_new_data", int'(r_resp_data), 7);
    repeat (3) step();

    // Buffered write to 3 under a continuous read stream.
    step(); idle(); w_req_valid = 1'b1; w_req_addr = AW'(3); w_req_data = DW'(5'h0C);
    samp();
    chk("starve_w_accept", int'(w_req_ready), 1);
    for (int k = 1; k <= 5; k++) begin
      step(); idle(); r_req_valid = 1'b1; r_req_addr = AW'(40 + k);
      samp();
      if (k < 5) begin
        chk("starve_r_ready_open", int'(r_req_ready), 1);
        chk("starve_w_ready_busy", int'(w_req_ready), 0);
      end else begin
        chk("starve_r_ready_blocked", int'(r_req_ready), 0);
        chk("starve_drain_write", int'(sram_en && sram_wmode), 1);
        chk("starve_drain_addr", int'(sram_addr), 3);
        chk("starve_drain_data", int'(sram_wdata), 'h0C);
      end
    end
    step(); idle(); r_req_valid = 1'b1; r_req_addr = AW'(3);
    step(); idle();
    samp();
    chk("starve_rd3_valid", int'(r_resp_valid), 1);
    chk("starve_rd3_data", int'(r_resp_data), 'h0C);

    // Read-data behaviour on idle cycles after a response.
    step(); idle(); w_req_valid = 1'b1; w_req_addr = AW'(20); w_req_data = DW'(5'h11);
    step(); idle();
    step();
    step(); r_req_valid = 1'b1; r_req_addr = AW'(20);
    step(); idle();
    samp();
    chk("hold_resp_data", int'(r_resp_data), 'h11);
    for (int i = 0; i < 3; i++) begin
      step();
      samp();
      chk("hold_idle_valid", int'(r_resp_valid), 0);
`ifdef HOLD_READ_EN
      chk("hold_idle_data", int'(r_resp_data), 'h11);
`else
      chk("pass_idle_data", int'(r_resp_data), int'(sram_rdata));
`endif
    end

    // Random traffic on a small address window to exercise forwarding.
    for (int i = 0; i < 3000; i++) begin
      step();
      r_req_valid = ($urandom % 4) != 0;
      r_req_addr  = AW'($urandom % 16);
      w_req_valid = ($urandom % 2) != 0;
      w_req_addr  = AW'($urandom_range(0, 15));
      w_req_data  = DW'($urandom);
    end
    step(); idle();
    repeat (8) step();
    samp();
    chk("random_queue_drained", exp_q.size(), 0);

    // Reset with a buffered write and a read in flight, then mid-sweep reset.
    step(); idle(); w_req_valid = 1'b1; w_req_addr = AW'(9); w_req_data = DW'(5'h15);
    r_req_valid = 1'b1; r_req_addr = AW'(2);
    samp();
    chk("lost_w_accept", int'(w_req_ready), 1);
    apply_reset(2);
    sweep_check(1000);
    apply_reset(2);
    sweep_check(int'(DEPTH));
    samp();
    chk("reinit_done", int'(init_done), 1);
    step(); r_req_valid = 1'b1; r_req_addr = AW'(9);
    step(); idle();
    samp();
    chk("lost_rd9_valid", int'(r_resp_valid), 1);
    chk("lost_rd9_data", int'(r_resp_data), 0);
    repeat (4) step();
    samp();
    chk("final_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_1p_front.md
SRAM_1P_FRONT -- requirements
Module: sram_1p_front

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 5, SRAM entry width.
REQ-003 SHALL have parameter DEPTH, default 2048, entries swept by init.
REQ-004 SHALL have parameter INIT_VAL, default 0, value written to every entry by init.
REQ-005 SHALL have parameter STARVE_MAX, default 4, cycles a buffered write may wait before it gains priority.
REQ-006 SHALL use one clock and a synchronous, active-high reset, with these ports:
  clock  in  1  sole clock, rising edge.
  reset  in  1  synchronous, active-high.
  r_req_valid  in  1  read request.
  r_req_ready  out  1  read accepted when valid&ready.
  r_req_addr  in  ADDR_W  read address.
  r_resp_valid  out  1  read data valid.
  r_resp_data  out  DATA_W  read data.
  w_req_valid  in  1  write request.
  w_req_ready  out  1  write accepted when valid&ready.
  w_req_addr  in  ADDR_W  write address.
  w_req_data  in  DATA_W  write data.
  init_done  out  1  high once the init sweep is complete.
  sram_en  out  1  SRAM port enable.
  sram_wmode  out  1  1 = write, 0 = read.
  sram_addr  out  ADDR_W  SRAM address.
  sram_wdata  out  DATA_W  SRAM write data.
  sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read enable.

Function
REQ-007 SHALL implement a two-state FSM with states INIT and RUN; reset forces INIT and sets the sweep counter to 0.
REQ-008 In INIT, each cycle SHALL write INIT_VAL to the SRAM at the counter address (sram_en=1, sram_wmode=1) and then increment the counter.
REQ-009 In INIT, r_req_ready, w_req_ready and init_done SHALL be 0.
REQ-010 After address DEPTH-1 is written, the FSM SHALL enter RUN on the next cycle; the sweep SHALL take exactly DEPTH cycles.
REQ-011 init_done SHALL be 1 in RUN.
REQ-012 The block SHALL hold a one-entry write buffer (wb_valid, wb_addr, wb_data, wb_age).
REQ-013 w_req_ready SHALL equal RUN && (!wb_valid || wb_drain), where wb_drain means the buffer writes to the SRAM this cycle.
REQ-014 A buffered write SHALL be visible to reads no earlier than the cycle after it is accepted.
REQ-015 Port arbitration in RUN:
  - If wb_valid && wb_age>=STARVE_MAX, the write SHALL drain and r_req_ready SHALL be 0.
  - Otherwise r_req_ready SHALL be 1; a read fire SHALL drive sram_en=1, sram_wmode=0, sram_addr=r_req_addr.
  - With no read fire and wb_valid, the write SHALL drain.
  - With neither, sram_en SHALL be 0.
REQ-016 wb_age SHALL clear on buffer load and increment, saturating, on each cycle the buffer is valid and not drained.
REQ-017 r_resp_valid SHALL be 1 exactly one cycle after each read fire; read latency is 1.
REQ-018 If a read fires while wb_valid and r_req_addr==wb_addr, the response data SHALL be wb_data (forwarding); otherwise it SHALL be sram_rdata.
REQ-019 A write accepted in the same cycle as a read to the same address SHALL NOT be forwarded; the read returns the prior contents.
REQ-020 Back-to-back reads SHALL sustain one per cycle while the starvation rule is not triggered.

Reset
REQ-021 While reset is asserted, the outputs SHALL be: sram_en=0, r_req_ready=0, w_req_ready=0, r_resp_valid=0, init_done=0, r_resp_data=0.
REQ-022 Reset asserted mid-operation SHALL discard the write buffer and any in-flight response and restart the sweep at address 0.

Configuration
REQ-023 Macro HOLD_READ_EN SHALL select how r_resp_data behaves when r_resp_valid=0:
  - Defined: r_resp_data SHALL hold the last valid response data.
  - Undefined: r_resp_data SHALL pass sram_rdata combinationally and is meaningful only when r_resp_valid=1.

Structure
REQ-024 Package sram_1p_front_pkg SHALL hold the default ADDR_W, DATA_W, DEPTH and STARVE_MAX, and the FSM state enum.
REQ-025 The write buffer, including its age counter and forward compare, SHALL be the sub-module sram_1p_front_wbuf; the SRAM array SHALL sit outside this block.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
  - Reset release -> 2048 consecutive write cycles, addresses 0..2047, data 0; init_done rises on cycle 2049.
  - Read addr 5 after init -> r_resp_valid=1 the next cycle with data 0.
  - Write addr 7 data 0x1A, then read addr 7 the following cycle (buffer not drained) -> forwarded 0x1A.
  - Continuous read stream while a write to addr 3 is buffered -> write drains on the 5th cycle, r_req_ready=0 that cycle; a later read of addr 3 returns its data.
  - Reset asserted at sweep address 1000 -> sweep restarts at 0; the buffered write is lost.
  - With HOLD_READ_EN: read returns 0x11, then idle -> r_resp_data stays 0x11.
